// File: rtl/ucsbece152a_count_ctrl.sv
// Step/direction input conditioner for the up/down counter.
// Synchronizes and debounces a push-button and a direction switch, and turns presses into one-cycle step pulses with auto-repeat.
module ucsbece152a_count_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 10,
   parameter int unsigned REPEAT_PERIOD   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   input  logic sw_dir_i,
   output logic step_o,
   output logic dir_o
);

   localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned TW   = $clog2(TMAX) + 1;
   localparam int unsigned NCH  = 2;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   // Channel 0 is the button, channel 1 the direction switch.
   logic [NCH-1:0] raw;
   logic [NCH-1:0] s1, s2, stable, stable_next;
   logic [CW-1:0]  cnt      [NCH];
   logic [CW-1:0]  cnt_next [NCH];

   state_t        state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic          step_next;
   logic          btn_now, btn_new;

   assign raw     = {sw_dir_i, btn_i};
   assign btn_now = stable[0];
   assign btn_new = stable_next[0];
   assign dir_o   = stable[1];

   // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         stable_next[i] = stable[i];
         cnt_next[i]    = '0;
         if (s2[i] != stable[i]) begin
            if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               stable_next[i] = s2[i];
            end else begin
               cnt_next[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1     <= '0;
         s2     <= '0;
         stable <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1     <= raw;
         s2     <= s1;
         stable <= stable_next;
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   // Step FSM looks at the debounced value being loaded this edge so the pulse aligns with it.
   always_comb begin
      state_next = state;
      timer_next = timer;
      step_next  = 1'b0;
      case (state)
         IDLE: begin
            if (btn_new && !btn_now) begin
               step_next  = 1'b1;
               state_next = DELAY;
               timer_next = TW'(REPEAT_DELAY - 1);
            end
         end
         DELAY: begin
            if (!btn_new) begin
               state_next = IDLE;
            end else if (timer == '0) begin
               if (REPEAT_EN) begin
                  step_next  = 1'b1;
                  state_next = REPEAT;
                  timer_next = TW'(REPEAT_PERIOD - 1);
               end
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         REPEAT: begin
            if (!btn_new) begin
               state_next = IDLE;
            end else if (timer == '0) begin
               step_next  = 1'b1;
               timer_next = TW'(REPEAT_PERIOD - 1);
            end else begin
               timer_next = timer - TW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         timer  <= '0;
         step_o <= 1'b0;
      end else begin
         state  <= state_next;
         timer  <= timer_next;
         step_o <= step_next;
      end
   end

endmodule

// File: tb/tb_ucsbece152a_count_ctrl.sv
// Bench for ucsbece152a_count_ctrl: an edge-indexed reference model checked every cycle,
// plus directed press/bounce/reset scenarios with literal step/direction edge lists.
module tb_ucsbece152a_count_ctrl;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;
   localparam int NMAX = 4096;

   logic clk, rst, btn, sw;
   logic step, dir, step_nr, dir_nr;

   int checks = 0;
   int fails  = 0;

   ucsbece152a_count_ctrl dut (
      .clk(clk), .rst(rst), .btn_i(btn), .sw_dir_i(sw), .step_o(step), .dir_o(dir)
   );

   ucsbece152a_count_ctrl #(.REPEAT_EN(1'b0)) dut_nr (
      .clk(clk), .rst(rst), .btn_i(btn), .sw_dir_i(sw), .step_o(step_nr), .dir_o(dir_nr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: raw samples indexed by edge number since reset release.
   logic cap_b [NMAX];
   logic cap_d [NMAX];
   int   n = 0;
   int   base = 0;
   int   press = 0;
   logic stb_b = 1'b0, stb_d = 1'b0;
   logic m_step = 1'b0, m_step_nr = 1'b0;
   logic prev_dir = 1'b0;
   int   step_log[$], nr_log[$], dir_log[$];
   int   exp_q[$];

   function automatic logic cap_at(input int k, input bit is_dir);
      if (k < 0) return 1'b0;
      return is_dir ? cap_d[k] : cap_b[k];
   endfunction

   // Debounced value flips once the last D synchronized samples all disagree with it.
   function automatic logic deb(input logic cur, input int e, input bit is_dir);
      for (int k = e - 1 - D; k <= e - 2; k++) begin
         if (cap_at(k, is_dir) == cur) return cur;
      end
      return ~cur;
   endfunction

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s edge %0d: got %0b expected %0b", name, n, got, exp);
      end
   endtask

   task automatic check_q(input string name, input int got[$], input int exp[$]);
      bit ok;
      ok = (got.size() == exp.size());
      if (ok) begin
         for (int i = 0; i < got.size(); i++) begin
            if (got[i] != exp[i]) ok = 1'b0;
         end
      end
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got edges %p expected %p", name, got, exp);
      end
   endtask

   // Per-cycle model update and comparison, 1 time unit after each rising edge.
   always begin
      logic old_b, old_d;
      int dd;
      @(posedge clk);
      #1;
      if (rst) begin
         n = 0; stb_b = 1'b0; stb_d = 1'b0;
         m_step = 1'b0; m_step_nr = 1'b0;
      end else begin
         cap_b[n] = btn;
         cap_d[n] = sw;
         old_b = stb_b;
         old_d = stb_d;
         stb_b = deb(old_b, n, 1'b0);
         stb_d = deb(old_d, n, 1'b1);
         m_step = 1'b0;
         m_step_nr = 1'b0;
         if (stb_b && !old_b) begin
            m_step = 1'b1;
            m_step_nr = 1'b1;
            press = n;
         end else if (stb_b && old_b) begin
            dd = n - press;
            m_step = (dd >= RD) && (((dd - RD) % RP) == 0);
         end
      end
      chk1("step", step, m_step);
      chk1("dir", dir, stb_d);
      chk1("step_norepeat", step_nr, m_step_nr);
      chk1("dir_norepeat", dir_nr, stb_d);
      if (step)             step_log.push_back(n - base);
      if (step_nr)          nr_log.push_back(n - base);
      if (dir && !prev_dir) dir_log.push_back(n - base);
      prev_dir = dir;
      if (!rst) n++;
   end

   task automatic run(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic start_test();
      base = n;
      step_log.delete();
      nr_log.delete();
      dir_log.delete();
   endtask

   task automatic press_btn(input int hold, input int tail);
      start_test();
      btn = 1'b1;
      run(hold);
      btn = 1'b0;
      run(tail);
   endtask

   initial begin
      rst = 1'b1; btn = 1'b1; sw = 1'b1;
      run(3);
      chk1("reset_step", step, 1'b0);
      chk1("reset_dir", dir, 1'b0);

      // Inputs held through reset release register as a fresh press and direction change.
      rst = 1'b0;
      start_test();
      run(12);
      exp_q = '{5};
      check_q("rst_release_step", step_log, exp_q);
      check_q("rst_release_dir", dir_log, exp_q);
      btn = 1'b0; sw = 1'b0;
      run(20);

      press_btn(3, 15);
      exp_q.delete();
      check_q("short_glitch", step_log, exp_q);

      press_btn(8, 15);
      exp_q = '{5};
      check_q("single_press", step_log, exp_q);

      press_btn(30, 15);
      exp_q = '{5, 15, 18, 21, 24, 27, 30, 33};
      check_q("held_repeat", step_log, exp_q);
      exp_q = '{5};
      check_q("held_no_repeat", nr_log, exp_q);

      // Direction switch with two short bounces before settling high.
      start_test();
      sw = 1'b1; run(2);
      sw = 1'b0; run(2);
      sw = 1'b1; run(2);
      sw = 1'b0; run(2);
      sw = 1'b1; run(15);
      exp_q = '{13};
      check_q("dir_bounce", dir_log, exp_q);
      exp_q.delete();
      check_q("dir_no_step", step_log, exp_q);
      sw = 1'b0;
      run(15);

      // Reset during repeat cancels the pending step immediately.
      start_test();
      btn = 1'b1;
      run(21);
      rst = 1'b1;
      #1;
      chk1("mid_reset_step", step, 1'b0);
      chk1("mid_reset_dir", dir, 1'b0);
      run(5);
      btn = 1'b0;
      rst = 1'b0;
      run(15);
      exp_q = '{5, 15, 18};
      check_q("mid_reset_steps", step_log, exp_q);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
